// File: rtl/his_readout_fsm_pkg.sv
// Shared types for the histogram readout block: FSM state encoding.
package his_readout_fsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_LAT   = 3'd2,
    S_SEND  = 3'd3,
    S_PEAK  = 3'd4,
    S_FIN   = 3'd5
  } state_e;

endpackage

// File: rtl/his_readout_fsm_peak_tracker.sv
// Running maximum of one histogram; the strict compare keeps the lowest bin on ties.
module his_peak_tracker #(
  parameter int NB     = 6,
  parameter int PEAK_W = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              clr_i,
  input  logic              upd_i,
  input  logic [PEAK_W-1:0] count_i,
  input  logic [NB-1:0]     bin_i,
  output logic [PEAK_W-1:0] max_o,
  output logic [NB-1:0]     bin_o
);

  logic [PEAK_W-1:0] max_q;
  logic [NB-1:0]     bin_q;

  always_ff @(posedge clk) begin
    if (!res || clr_i) begin
      max_q <= '0;
      bin_q <= '0;
    end else if (upd_i && (count_i > max_q)) begin
      max_q <= count_i;
      bin_q <= bin_i;
    end
  end

  assign max_o = max_q;
  assign bin_o = bin_q;

endmodule

// File: rtl/his_readout_fsm.sv
// Reader side of the ping-pong histogram RAM: streams each bin of a bank,
// reports per-pixel peaks and optionally clears every bin after reading it.
module his_readout_fsm
  import his_readout_fsm_pkg::*;
#(
  parameter int NB          = 6,
  parameter int PEAK_W      = 16,
  parameter int PIXELS      = 4,
  parameter int PIX_W       = 2,
  parameter bit CLEAR_ON_RD = 1'b1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic                  bank_sel,
  output logic                  rd_en,
  output logic [PIX_W+NB:0]     rd_addr,
  input  logic [PEAK_W-1:0]     rd_data,
  output logic                  clr_en,
  output logic [PIX_W+NB:0]     clr_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PIX_W-1:0]      out_pixel,
  output logic [NB-1:0]         out_bin,
  output logic [PEAK_W-1:0]     out_count,
  output logic                  out_last,
  output logic                  peak_valid,
  output logic [PIX_W-1:0]      peak_pixel,
  output logic [NB-1:0]         peak_bin,
  output logic [PEAK_W-1:0]     peak_count,
  output logic                  busy,
  output logic                  done
);

  localparam int BINS = 1 << NB;

  state_e            state_q, state_d;
  logic              bank_q, bank_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [NB-1:0]     bin_q, bin_d;
  logic [PEAK_W-1:0] cnt_q;
  logic [PIX_W-1:0]  opix_q;
  logic [NB-1:0]     obin_q;
  logic              last_q;
  logic [PEAK_W-1:0] pk_max;
  logic [NB-1:0]     pk_bin;
  logic              in_lat, in_peak;

  assign in_lat  = (state_q == S_LAT);
  assign in_peak = (state_q == S_PEAK);

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= S_IDLE;
      bank_q  <= 1'b0;
      pix_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      opix_q  <= '0;
      obin_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      pix_q   <= pix_d;
      bin_q   <= bin_d;
      if (in_lat) begin
        cnt_q  <= rd_data;
        opix_q <= pix_q;
        obin_q <= bin_q;
        last_q <= (bin_q == NB'(BINS - 1));
      end
    end
  end

  // The next read is issued in the handshake cycle itself, so bin_d is the
  // address being fetched whenever rd_en is high.
  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    pix_d    = pix_q;
    bin_d    = bin_q;
    rd_en    = 1'b0;
    rd_addr  = '0;
    clr_en   = 1'b0;
    clr_addr = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          bank_d  = bank_sel;
          pix_d   = '0;
          bin_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rd_en   = 1'b1;
        state_d = S_LAT;
      end
      S_LAT: begin
        clr_en  = CLEAR_ON_RD;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = S_PEAK;
          end else begin
            bin_d   = bin_q + NB'(1);
            rd_en   = 1'b1;
            state_d = S_LAT;
          end
        end
      end
      S_PEAK: begin
        if (pix_q == PIX_W'(PIXELS - 1)) begin
          state_d = S_FIN;
        end else begin
          pix_d   = pix_q + PIX_W'(1);
          bin_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rd_en)  rd_addr  = {bank_q, pix_q, bin_d};
    if (clr_en) clr_addr = {bank_q, pix_q, bin_q};
  end

  his_peak_tracker #(
    .NB     (NB),
    .PEAK_W (PEAK_W)
  ) u_peak (
    .clk     (clk),
    .res     (res),
    .clr_i   (in_peak),
    .upd_i   (in_lat),
    .count_i (rd_data),
    .bin_i   (bin_q),
    .max_o   (pk_max),
    .bin_o   (pk_bin)
  );

  assign out_valid  = (state_q == S_SEND);
  assign out_pixel  = opix_q;
  assign out_bin    = obin_q;
  assign out_count  = cnt_q;
  assign out_last   = last_q;
  assign peak_valid = in_peak;
  assign peak_pixel = in_peak ? pix_q  : '0;
  assign peak_bin   = in_peak ? pk_bin : '0;
  assign peak_count = in_peak ? pk_max : '0;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);

endmodule
